kl8e_tty: RTL and testbench

//  CPU-side console controller sitting between the PDP-8 IOT bus and the UART's parallel

---
 rtl/kl8e_tty.sv | 161 ++++++++++++++++
 tb/tb_kl8e_tty.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kl8e_tty.sv
// KL8E console controller: keyboard/teleprinter IOT decode, keyboard
// buffer and flags, UART rx/tx handshakes and console interrupt request.
// Ports: clk, reset (async high); iotStb/iotOp/ac in, acClr/orData/skip out
// (combinational); irq out; rxData/rxRdy in, rxAck out; txData/txStb out,
// txRdy in.
module kl8e_tty #(
  parameter logic [5:0] KBD_DEV = 6'o03,
  parameter logic [5:0] TTY_DEV = 6'o04,
  parameter bit         RX_MARK = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iotStb,
  input  logic [8:0]  iotOp,
  input  logic [11:0] ac,
  output logic        acClr,
  output logic [11:0] orData,
  output logic        skip,
  output logic        irq,
  input  logic [7:0]  rxData,
  input  logic        rxRdy,
  output logic        rxAck,
  output logic [7:0]  txData,
  output logic        txStb,
  input  logic        txRdy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SEND  = 2'd1;
  localparam logic [1:0] S_WLOW  = 2'd2;
  localparam logic [1:0] S_WHIGH = 2'd3;

  logic [1:0] st_q, st_d;
  logic       kbd_q, kbd_d;
  logic       tty_q, tty_d;
  logic       ien_q, ien_d;
  logic [7:0] buf_q, buf_d;
  logic [7:0] txd_q, txd_d;
  logic       stb_q, stb_d;
  logic       ack_q, ack_d;
  logic       irq_q, irq_d;

  logic       kbd_hit, tty_hit;
  logic [2:0] op;
  logic       kbd_clr, ien_ld;
  logic       tty_set, tty_clr;
  logic       start, done, capture;
  logic       unused;

  assign unused  = ^ac[11:8];
  assign op      = iotOp[2:0];
  assign kbd_hit = iotStb && (iotOp[8:3] == KBD_DEV);
  assign tty_hit = iotStb && (iotOp[8:3] == TTY_DEV);

  always_comb begin
    acClr   = 1'b0;
    orData  = 12'd0;
    skip    = 1'b0;
    kbd_clr = 1'b0;
    ien_ld  = 1'b0;
    tty_set = 1'b0;
    tty_clr = 1'b0;
    start   = 1'b0;
    if (kbd_hit) begin
      case (op)
        3'd0: kbd_clr = 1'b1;
        3'd1: skip = kbd_q;
        3'd2: begin
          acClr   = 1'b1;
          kbd_clr = 1'b1;
        end
        3'd4: orData = {4'b0, buf_q};
        3'd5: ien_ld = 1'b1;
        3'd6: begin
          acClr   = 1'b1;
          orData  = {4'b0, buf_q};
          kbd_clr = 1'b1;
        end
        default: ;
      endcase
    end
    if (tty_hit) begin
      case (op)
        3'd0: tty_set = 1'b1;
        3'd1: skip = tty_q;
        3'd2: tty_clr = 1'b1;
        3'd4: start = 1'b1;
        3'd5: skip = kbd_q | tty_q;
        3'd6: begin
          tty_clr = 1'b1;
          start   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // A clear and a capture never share a cycle: the held byte
  // is taken on the cycle after the flag drops.
  assign capture = rxRdy && !kbd_q && !kbd_clr;

  always_comb begin
    st_d  = st_q;
    txd_d = txd_q;
    stb_d = 1'b0;
    done  = 1'b0;
    case (st_q)
      S_IDLE: if (start) begin
        txd_d = ac[7:0];
        st_d  = S_SEND;
      end
      S_SEND: if (txRdy) begin
        stb_d = 1'b1;
        st_d  = S_WLOW;
      end
      S_WLOW: if (!txRdy) st_d = S_WHIGH;
      default: if (txRdy) begin
        done = 1'b1;
        st_d = S_IDLE;
      end
    endcase
  end

  // Print completion beats a same-cycle TCF/TLS clear.
  assign tty_d = done | tty_set | (tty_q & ~tty_clr);
  assign kbd_d = kbd_clr ? 1'b0 : (capture | kbd_q);
  assign buf_d = capture ? {rxData[7] | RX_MARK, rxData[6:0]} : buf_q;
  assign ien_d = ien_ld ? ac[0] : ien_q;
  assign irq_d = ien_q & (kbd_q | tty_q);
  assign ack_d = capture;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q  <= S_IDLE;
      kbd_q <= 1'b0;
      tty_q <= 1'b0;
      ien_q <= 1'b1;
      buf_q <= 8'd0;
      txd_q <= 8'd0;
      stb_q <= 1'b0;
      ack_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      kbd_q <= kbd_d;
      tty_q <= tty_d;
      ien_q <= ien_d;
      buf_q <= buf_d;
      txd_q <= txd_d;
      stb_q <= stb_d;
      ack_q <= ack_d;
      irq_q <= irq_d;
    end
  end

  assign irq    = irq_q;
  assign rxAck  = ack_q;
  assign txData = txd_q;
  assign txStb  = stb_q;

endmodule

// File: tb/tb_kl8e_tty.sv
// Self-checking bench for kl8e_tty: directed vector table, hand-written
// print/reset sequences and randomized traffic against a reference model.
module tb_kl8e_tty;

  logic        clk = 1'b0;
  logic        reset;
  logic        iotStb;
  logic [8:0]  iotOp;
  logic [11:0] ac;
  logic        acClr;
  logic [11:0] orData;
  logic        skip;
  logic        irq;
  logic [7:0]  rxData;
  logic        rxRdy;
  logic        rxAck;
  logic [7:0]  txData;
  logic        txStb;
  logic        txRdy;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  kl8e_tty dut (
    .clk(clk), .reset(reset),
    .iotStb(iotStb), .iotOp(iotOp), .ac(ac),
    .acClr(acClr), .orData(orData), .skip(skip), .irq(irq),
    .rxData(rxData), .rxRdy(rxRdy), .rxAck(rxAck),
    .txData(txData), .txStb(txStb), .txRdy(txRdy)
  );

  typedef struct {
    logic        stb;
    logic [8:0]  op;
    logic [11:0] a;
    logic        rr;
    logic [7:0]  rd;
    logic        eclr;
    logic [11:0] eor;
    logic        eskip;
    logic        eirq;
    logic        eack;
  } vec_t;

  function automatic vec_t mk(logic s, logic [8:0] o, logic [11:0] a,
      logic r, logic [7:0] d, logic c, logic [11:0] e, logic k,
      logic i, logic q);
    vec_t v;
    v.stb = s; v.op = o; v.a = a; v.rr = r; v.rd = d;
    v.eclr = c; v.eor = e; v.eskip = k; v.eirq = i; v.eack = q;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
      input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [8:0] o,
      input logic [11:0] a, input logic r, input logic [7:0] d,
      input logic t);
    iotStb = s; iotOp = o; ac = a; rxRdy = r; rxData = d; txRdy = t;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    drive(0, 9'd0, 12'd0, 0, 8'd0, 1);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Reference model state
  logic       m_kf, m_tf, m_ien, m_irq, m_ack, m_stb;
  logic [7:0] m_buf, m_txd;
  int         m_ph;

  task automatic model_reset;
    m_kf = 0; m_tf = 0; m_ien = 1; m_irq = 0; m_ack = 0; m_stb = 0;
    m_buf = 0; m_txd = 0; m_ph = 0;
  endtask

  task automatic model_out(output logic [24:0] e);
    logic c, k;
    logic [11:0] o;
    logic kd, td;
    c = 0; k = 0; o = 0;
    kd = iotStb && iotOp[8:3] == 6'o03;
    td = iotStb && iotOp[8:3] == 6'o04;
    if (kd) begin
      if (iotOp[2:0] == 1) k = m_kf;
      if (iotOp[2:0] == 2 || iotOp[2:0] == 6) c = 1;
      if (iotOp[2:0] == 4 || iotOp[2:0] == 6) o = 12'(m_buf);
    end
    if (td) begin
      if (iotOp[2:0] == 1) k = m_tf;
      if (iotOp[2:0] == 5) k = m_kf | m_tf;
    end
    e = {c, o, k, m_irq, m_ack, m_stb, m_txd};
  endtask

  task automatic model_edge;
    logic kd, td, kclr, cap, done;
    int o;
    kd = iotStb && iotOp[8:3] == 6'o03;
    td = iotStb && iotOp[8:3] == 6'o04;
    o = int'(iotOp[2:0]);
    kclr = kd && (o == 0 || o == 2 || o == 6);
    cap = rxRdy && !m_kf && !kclr;
    done = 0;
    m_irq = m_ien && (m_kf || m_tf);
    m_ack = cap;
    m_stb = 0;
    if (m_ph == 0 && td && (o == 4 || o == 6)) begin
      m_txd = ac[7:0];
      m_ph = 1;
    end else if (m_ph == 1 && txRdy) begin
      m_stb = 1;
      m_ph = 2;
    end else if (m_ph == 2 && !txRdy) begin
      m_ph = 3;
    end else if (m_ph == 3 && txRdy) begin
      done = 1;
      m_ph = 0;
    end
    if (done || (td && o == 0)) m_tf = 1;
    else if (td && (o == 2 || o == 6)) m_tf = 0;
    if (kclr) m_kf = 0;
    else if (cap) begin
      m_kf = 1;
      m_buf = rxData | 8'h80;
    end
    if (kd && o == 5) m_ien = ac[0];
  endtask

  vec_t tbl[27];
  logic [24:0] act, exp;
  int stbcnt;
  logic early;
  logic rr;
  logic [7:0] rd;
  logic [5:0] dev;

  initial begin
    reset = 1'b0;
    drive(0, 9'd0, 12'd0, 0, 8'd0, 1);

    tbl[0]  = mk(0, 9'o000, 12'o0, 0, 8'h00, 0, 12'o0,    0, 0, 0);
    tbl[1]  = mk(1, 9'o031, 12'o0, 0, 8'h00, 0, 12'o0,    0, 0, 0);
    tbl[2]  = mk(0, 9'o000, 12'o0, 1, 8'h41, 0, 12'o0,    0, 0, 0);
    tbl[3]  = mk(1, 9'o031, 12'o0, 1, 8'h41, 0, 12'o0,    1, 0, 1);
    tbl[4]  = mk(1, 9'o034, 12'o0, 1, 8'h42, 0, 12'o0301, 0, 1, 0);
    tbl[5]  = mk(0, 9'o000, 12'o0, 1, 8'h42, 0, 12'o0,    0, 1, 0);
    tbl[6]  = mk(1, 9'o030, 12'o0, 1, 8'h42, 0, 12'o0,    0, 1, 0);
    tbl[7]  = mk(1, 9'o031, 12'o0, 1, 8'h42, 0, 12'o0,    0, 1, 0);
    tbl[8]  = mk(1, 9'o031, 12'o0, 0, 8'h00, 0, 12'o0,    1, 0, 1);
    tbl[9]  = mk(1, 9'o036, 12'o0, 0, 8'h00, 1, 12'o0302, 0, 1, 0);
    tbl[10] = mk(1, 9'o031, 12'o0, 0, 8'h00, 0, 12'o0,    0, 1, 0);
    tbl[11] = mk(1, 9'o035, 12'o0, 0, 8'h00, 0, 12'o0,    0, 0, 0);
    tbl[12] = mk(1, 9'o040, 12'o0, 0, 8'h00, 0, 12'o0,    0, 0, 0);
    tbl[13] = mk(0, 9'o000, 12'o0, 1, 8'h05, 0, 12'o0,    0, 0, 0);
    tbl[14] = mk(1, 9'o045, 12'o0, 0, 8'h00, 0, 12'o0,    1, 0, 1);
    tbl[15] = mk(1, 9'o034, 12'o0, 0, 8'h00, 0, 12'o0205, 0, 0, 0);
    tbl[16] = mk(1, 9'o035, 12'o1, 0, 8'h00, 0, 12'o0,    0, 0, 0);
    tbl[17] = mk(0, 9'o000, 12'o0, 0, 8'h00, 0, 12'o0,    0, 0, 0);
    tbl[18] = mk(1, 9'o041, 12'o0, 0, 8'h00, 0, 12'o0,    1, 1, 0);
    tbl[19] = mk(1, 9'o032, 12'o0, 0, 8'h00, 1, 12'o0,    0, 1, 0);
    tbl[20] = mk(1, 9'o042, 12'o0, 0, 8'h00, 0, 12'o0,    0, 1, 0);
    tbl[21] = mk(1, 9'o045, 12'o0, 0, 8'h00, 0, 12'o0,    0, 1, 0);
    tbl[22] = mk(0, 9'o000, 12'o0, 0, 8'h00, 0, 12'o0,    0, 0, 0);
    tbl[23] = mk(1, 9'o033, 12'o7777, 0, 8'h00, 0, 12'o0, 0, 0, 0);
    tbl[24] = mk(1, 9'o047, 12'o7777, 0, 8'h00, 0, 12'o0, 0, 0, 0);
    tbl[25] = mk(1, 9'o056, 12'o7777, 0, 8'h00, 0, 12'o0, 0, 0, 0);
    tbl[26] = mk(0, 9'o036, 12'o7777, 0, 8'h00, 0, 12'o0, 0, 0, 0);

    do_reset;
    for (int i = 0; i < 27; i++) begin
      drive(tbl[i].stb, tbl[i].op, tbl[i].a, tbl[i].rr, tbl[i].rd, 1);
      @(negedge clk);
      act = {acClr, orData, skip, irq, rxAck, txStb, txData};
      exp = {tbl[i].eclr, tbl[i].eor, tbl[i].eskip, tbl[i].eirq,
             tbl[i].eack, 1'b0, 8'h00};
      chk($sformatf("vec%0d", i), 32'(act), 32'(exp));
      tick;
    end

    // Reset while mid-print
    do_reset;
    drive(1, 9'o035, 12'o0, 0, 8'h00, 1); tick;
    drive(1, 9'o040, 12'o0, 0, 8'h00, 1); tick;
    drive(1, 9'o044, 12'h5A, 0, 8'h00, 1); tick;
    drive(0, 9'o000, 12'o0, 0, 8'h00, 1); tick;
    drive(0, 9'o000, 12'o0, 0, 8'h00, 0);
    #1 chk("t1_pre_stb", 32'(txStb), 32'd1);
    reset = 1'b1;
    #1;
    chk("t1_stb", 32'(txStb), 32'd0);
    chk("t1_irq", 32'(irq), 32'd0);
    tick;
    reset = 1'b0;
    drive(1, 9'o041, 12'o0, 0, 8'h00, 1);
    @(negedge clk);
    chk("t1_tty", 32'(skip), 32'd0);
    tick;
    drive(1, 9'o040, 12'o0, 0, 8'h00, 1); tick;
    drive(0, 9'o000, 12'o0, 0, 8'h00, 1); tick;
    @(negedge clk);
    chk("t1_ien", 32'(irq), 32'd1);
    tick;
    drive(1, 9'o044, 12'h33, 0, 8'h00, 1); tick;
    @(negedge clk);
    chk("t1_idle", 32'(txData), 32'h33);
    tick;

    // TLS full print handshake
    do_reset;
    stbcnt = 0;
    early = 0;
    drive(1, 9'o046, 12'o0215, 0, 8'h00, 1); tick;
    drive(0, 9'o000, 12'o0, 0, 8'h00, 1);
    @(negedge clk);
    chk("t4_data", 32'(txData), 32'h8D);
    stbcnt += int'(txStb);
    tick;
    drive(0, 9'o000, 12'o0, 0, 8'h00, 0);
    @(negedge clk);
    stbcnt += int'(txStb);
    tick;
    for (int i = 0; i < 99; i++) begin
      drive(1, 9'o041, 12'o0, 0, 8'h00, 0);
      @(negedge clk);
      stbcnt += int'(txStb);
      early |= skip;
      tick;
    end
    drive(0, 9'o000, 12'o0, 0, 8'h00, 1); tick;
    drive(1, 9'o041, 12'o0, 0, 8'h00, 1);
    @(negedge clk);
    stbcnt += int'(txStb);
    chk("t4_flag", 32'(skip), 32'd1);
    chk("t4_stb", 32'(stbcnt), 32'd1);
    chk("t4_early", 32'(early), 32'd0);
    tick;

    // TPC ignored while busy; set beats same-cycle TCF
    do_reset;
    drive(1, 9'o044, 12'h55, 0, 8'h00, 0); tick;
    drive(1, 9'o044, 12'hAA, 0, 8'h00, 0); tick;
    drive(0, 9'o000, 12'o0, 0, 8'h00, 0);
    @(negedge clk);
    chk("t6_data", 32'(txData), 32'h55);
    tick;
    drive(0, 9'o000, 12'o0, 0, 8'h00, 1); tick;
    drive(0, 9'o000, 12'o0, 0, 8'h00, 0); tick;
    drive(1, 9'o042, 12'o0, 0, 8'h00, 1); tick;
    drive(1, 9'o041, 12'o0, 0, 8'h00, 1);
    @(negedge clk);
    chk("t6_setwins", 32'(skip), 32'd1);
    tick;

    // Randomized traffic against the reference model
    do_reset;
    model_reset;
    rr = 0;
    rd = 0;
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 2))
        0: dev = 6'o03;
        1: dev = 6'o04;
        default: dev = 6'($urandom);
      endcase
      drive(1'($urandom_range(0, 1)), {dev, 3'($urandom)},
            12'($urandom), rr, rd, $urandom_range(0, 2) != 0);
      @(negedge clk);
      model_out(exp);
      act = {acClr, orData, skip, irq, rxAck, txStb, txData};
      chk($sformatf("rnd%0d", i), 32'(act), 32'(exp));
      model_edge;
      @(posedge clk);
      if (rr && rxAck) rr = 0;
      else if (!rr && $urandom_range(0, 3) == 0) begin
        rr = 1;
        rd = 8'($urandom);
      end
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
